// File: rtl/uart_rx_fifo_ctrl.sv
// Receive-side frame FIFO with status bits, RTS hysteresis flow control,
// and overrun / timeout / level-threshold interrupt generation.
module uart_rx_fifo_ctrl #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned RTS_HI       = 12,
    parameter int unsigned RTS_LO       = 4,
    parameter int unsigned TIMEOUT_BITS = 40
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       rx_en_i,
    input  logic                       frame_valid_i,
    input  logic [DATA_W-1:0]          frame_data_i,
    input  logic                       parity_err_i,
    input  logic                       frame_err_i,
    input  logic                       bit_tick_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic                       clr_ovr_i,
    input  logic [$clog2(DEPTH):0]     thr_i,
    output logic [DATA_W-1:0]          rd_data_o,
    output logic                       rd_perr_o,
    output logic                       rd_ferr_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       rts_no,
    output logic                       overrun_o,
    output logic                       timeout_o,
    output logic                       irq_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_BITS + 1);
    localparam int unsigned EW = DATA_W + 2;

    typedef enum logic [1:0] {
        FLOW_DISABLED,
        FLOW_ASSERTED,
        FLOW_THROTTLED
    } flow_state_t;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_nxt;
    logic [TW-1:0] tmo_cnt;
    logic          fv_d;
    logic          overrun_q;
    logic          irq_q;
    flow_state_t   state_q;
    flow_state_t   state_nxt;

    logic push_req;
    logic pop_req;
    logic wr_en;
    logic rd_en;
    logic ovr_set;
    logic is_empty;
    logic is_full;
    logic tmo_hit;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
    always_comb begin
        is_empty = (level_q == '0);
        is_full  = (level_q == LW'(DEPTH));
        tmo_hit  = (tmo_cnt == TW'(TIMEOUT_BITS));
        push_req = rx_en_i & frame_valid_i & ~fv_d;
        pop_req  = pop_i & ~is_empty;
        wr_en    = ~flush_i & push_req & (~is_full | pop_req);
        rd_en    = ~flush_i & pop_req;
        ovr_set  = ~flush_i & push_req & is_full & ~pop_req;
        level_nxt = level_q;
        if (flush_i) begin
            level_nxt = '0;
        end else if (wr_en && !rd_en) begin
            level_nxt = level_q + LW'(1);
        end else if (rd_en && !wr_en) begin
            level_nxt = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_q   <= '0;
            fv_d      <= 1'b0;
            overrun_q <= 1'b0;
            tmo_cnt   <= '0;
            irq_q     <= 1'b0;
        end else begin
            fv_d    <= frame_valid_i;
            level_q <= level_nxt;
            if (flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + AW'(1);
                if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            end
            if (ovr_set) begin
                overrun_q <= 1'b1;
            end else if (clr_ovr_i) begin
                overrun_q <= 1'b0;
            end
            if (flush_i || wr_en || rd_en || is_empty) begin
                tmo_cnt <= '0;
            end else if (bit_tick_i && !tmo_hit) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
            irq_q <= ((thr_i != '0) && (level_q >= thr_i)) || tmo_hit || overrun_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && wr_en) begin
            mem[wr_ptr] <= {frame_err_i, parity_err_i, frame_data_i};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= FLOW_DISABLED;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Throttle looks at the upcoming level so rts_no rises together with level_o.
    always_comb begin
        state_nxt = state_q;
        if (!rx_en_i) begin
            state_nxt = FLOW_DISABLED;
        end else begin
            case (state_q)
                FLOW_DISABLED:  if (level_q < LW'(RTS_HI))    state_nxt = FLOW_ASSERTED;
                FLOW_ASSERTED:  if (level_nxt >= LW'(RTS_HI)) state_nxt = FLOW_THROTTLED;
                FLOW_THROTTLED: if (level_q <= LW'(RTS_LO))   state_nxt = FLOW_ASSERTED;
                default:        state_nxt = FLOW_DISABLED;
            endcase
        end
    end

    assign {rd_ferr_o, rd_perr_o, rd_data_o} = is_empty ? '0 : mem[rd_ptr];
    assign empty_o   = is_empty;
    assign full_o    = is_full;
    assign level_o   = level_q;
    assign rts_no    = (state_q != FLOW_ASSERTED);
    assign overrun_o = overrun_q;
    assign timeout_o = tmo_hit;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Bench for uart_rx_fifo_ctrl: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_rx_fifo_ctrl;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int RTS_HI = 12;
    localparam int RTS_LO = 4;
    localparam int TMO    = 40;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic              clk;
    logic              reset_n;
    logic              rx_en_i;
    logic              frame_valid_i;
    logic [DATA_W-1:0] frame_data_i;
    logic              parity_err_i;
    logic              frame_err_i;
    logic              bit_tick_i;
    logic              pop_i;
    logic              flush_i;
    logic              clr_ovr_i;
    logic [LW-1:0]     thr_i;
    logic [DATA_W-1:0] rd_data_o;
    logic              rd_perr_o;
    logic              rd_ferr_o;
    logic              empty_o;
    logic              full_o;
    logic [LW-1:0]     level_o;
    logic              rts_no;
    logic              overrun_o;
    logic              timeout_o;
    logic              irq_o;

    uart_rx_fifo_ctrl #(
        .DATA_W(DATA_W),
        .DEPTH(DEPTH),
        .RTS_HI(RTS_HI),
        .RTS_LO(RTS_LO),
        .TIMEOUT_BITS(TMO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .rx_en_i(rx_en_i),
        .frame_valid_i(frame_valid_i),
        .frame_data_i(frame_data_i),
        .parity_err_i(parity_err_i),
        .frame_err_i(frame_err_i),
        .bit_tick_i(bit_tick_i),
        .pop_i(pop_i),
        .flush_i(flush_i),
        .clr_ovr_i(clr_ovr_i),
        .thr_i(thr_i),
        .rd_data_o(rd_data_o),
        .rd_perr_o(rd_perr_o),
        .rd_ferr_o(rd_ferr_o),
        .empty_o(empty_o),
        .full_o(full_o),
        .level_o(level_o),
        .rts_no(rts_no),
        .overrun_o(overrun_o),
        .timeout_o(timeout_o),
        .irq_o(irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, flow control as a 0/1/2 mode
    // (0 = off, 1 = requesting, 2 = throttled).
    logic [DATA_W+1:0] q[$];
    bit m_prev;
    bit m_ovr;
    int m_tcnt;
    int m_mode;
    bit m_irq;

    always @(posedge clk) begin : model
        int  lvl, nl;
        bit  frame_edge, popok, wr, full;
        if (!reset_n) begin
            q.delete();
            m_prev = 0;
            m_ovr  = 0;
            m_tcnt = 0;
            m_mode = 0;
            m_irq  = 0;
        end else begin
            lvl        = q.size();
            full       = (lvl == DEPTH);
            frame_edge = rx_en_i && frame_valid_i && !m_prev;
            popok      = pop_i && (lvl != 0);
            m_irq      = ((thr_i != 0) && (lvl >= int'(thr_i))) || (m_tcnt == TMO) || m_ovr;
            if (flush_i) begin
                q.delete();
                m_tcnt = 0;
                if (clr_ovr_i) m_ovr = 0;
            end else begin
                wr = frame_edge && (!full || popok);
                if (popok) void'(q.pop_front());
                if (wr) q.push_back({frame_err_i, parity_err_i, frame_data_i});
                if (frame_edge && full && !popok) m_ovr = 1;
                else if (clr_ovr_i) m_ovr = 0;
                if (wr || popok || lvl == 0) m_tcnt = 0;
                else if (bit_tick_i && m_tcnt < TMO) m_tcnt = m_tcnt + 1;
            end
            nl = q.size();
            if (!rx_en_i) m_mode = 0;
            else if (m_mode == 0 && lvl < RTS_HI) m_mode = 1;
            else if (m_mode == 1 && nl >= RTS_HI) m_mode = 2;
            else if (m_mode == 2 && lvl <= RTS_LO) m_mode = 1;
            m_prev = frame_valid_i;
        end
    end

    always @(negedge clk) begin : compare
        if (chk_on) begin
            chk("level_o", level_o, q.size());
            chk("empty_o", empty_o, q.size() == 0);
            chk("full_o", full_o, q.size() == DEPTH);
            chk("rts_no", rts_no, m_mode != 1);
            chk("overrun_o", overrun_o, m_ovr);
            chk("timeout_o", timeout_o, m_tcnt == TMO);
            chk("irq_o", irq_o, m_irq);
            if (q.size() > 0) begin
                chk("rd_data_o", rd_data_o, q[0][DATA_W-1:0]);
                chk("rd_perr_o", rd_perr_o, q[0][DATA_W]);
                chk("rd_ferr_o", rd_ferr_o, q[0][DATA_W+1]);
            end
        end
    end

    task automatic push_frame(input logic [DATA_W-1:0] d, input logic p, input logic f);
        frame_data_i  = d;
        parity_err_i  = p;
        frame_err_i   = f;
        frame_valid_i = 1'b1;
        @(negedge clk);
        frame_valid_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic pop_n(input int n);
        pop_i = 1'b1;
        repeat (n) @(negedge clk);
        pop_i = 1'b0;
    endtask

    int pop_pct, push_pct;

    initial begin
        reset_n = 0; rx_en_i = 0; frame_valid_i = 0; frame_data_i = '0;
        parity_err_i = 0; frame_err_i = 0; bit_tick_i = 0; pop_i = 0;
        flush_i = 0; clr_ovr_i = 0; thr_i = '0;
        @(negedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        chk("rst_level", level_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_rts", rts_no, 1);
        chk("rst_irq", irq_o, 0);
        chk("rst_rd_data", rd_data_o, 0);

        reset_n = 1; rx_en_i = 1;
        @(negedge clk);
        push_frame(8'hA5, 1'b1, 1'b0);
        chk("t1_data", rd_data_o, 8'hA5);
        chk("t1_perr", rd_perr_o, 1);
        chk("t1_level", level_o, 1);
        chk("t1_rts", rts_no, 0);
        pop_n(1);
        chk("t1_empty", empty_o, 1);

        for (int i = 0; i < 12; i++) push_frame(8'(8'h10 + i), 1'b0, 1'b0);
        chk("t2_level12", level_o, 12);
        chk("t2_rts_hi", rts_no, 1);
        pop_n(7);
        chk("t2_level5", level_o, 5);
        chk("t2_rts_at5", rts_no, 1);
        pop_n(1);
        chk("t2_rts_at4", rts_no, 1);
        @(negedge clk);
        chk("t2_rts_after4", rts_no, 0);

        for (int i = 0; i < 12; i++) push_frame(8'(8'h20 + i), 1'b0, 1'b0);
        chk("t3_full", full_o, 1);
        push_frame(8'h3C, 1'b0, 1'b0);
        chk("t3_ovr", overrun_o, 1);
        chk("t3_level", level_o, 16);
        chk("t3_head", rd_data_o, 8'h18);
        frame_data_i = 8'h3C; frame_valid_i = 1; pop_i = 1;
        @(negedge clk);
        frame_valid_i = 0; pop_i = 0;
        @(negedge clk);
        chk("t3_pp_level", level_o, 16);
        chk("t3_pp_head", rd_data_o, 8'h19);
        clr_ovr_i = 1;
        @(negedge clk);
        clr_ovr_i = 0;
        chk("t3_clr", overrun_o, 0);
        pop_n(15);
        chk("t3_last", rd_data_o, 8'h3C);
        chk("t3_lvl1", level_o, 1);

        for (int i = 0; i < 39; i++) begin
            bit_tick_i = 1; @(negedge clk);
            bit_tick_i = 0; @(negedge clk);
        end
        chk("t4_tmo39", timeout_o, 0);
        bit_tick_i = 1; @(negedge clk);
        bit_tick_i = 0;
        chk("t4_tmo40", timeout_o, 1);
        chk("t4_irq_lag", irq_o, 0);
        @(negedge clk);
        chk("t4_irq", irq_o, 1);
        pop_n(1);
        chk("t4_tmo_clr", timeout_o, 0);

        thr_i = 3;
        push_frame(8'h01, 1'b0, 1'b1);
        push_frame(8'h02, 1'b0, 1'b0);
        frame_data_i = 8'h03; frame_valid_i = 1;
        @(negedge clk);
        frame_valid_i = 0;
        chk("t5_level3", level_o, 3);
        chk("t5_irq_lag", irq_o, 0);
        @(negedge clk);
        chk("t5_irq", irq_o, 1);
        flush_i = 1; frame_data_i = 8'h04; frame_valid_i = 1;
        @(negedge clk);
        flush_i = 0; frame_valid_i = 0;
        chk("t5_flush_lvl", level_o, 0);
        chk("t5_flush_ovr", overrun_o, 0);
        thr_i = 0; rx_en_i = 0;
        @(negedge clk);
        chk("t5_rts_dis", rts_no, 1);
        push_frame(8'h55, 1'b0, 1'b0);
        push_frame(8'h66, 1'b0, 1'b0);
        chk("t5_ignored", level_o, 0);

        rx_en_i = 1;
        @(negedge clk);
        for (int i = 0; i < 7; i++) push_frame(8'(8'h40 + i), 1'b0, 1'b0);
        chk("t6_level7", level_o, 7);
        reset_n = 0;
        @(negedge clk);
        chk("t6_level", level_o, 0);
        chk("t6_rts", rts_no, 1);
        chk("t6_ovr", overrun_o, 0);
        chk("t6_tmo", timeout_o, 0);
        reset_n = 1;

        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) begin
                pop_pct  = $urandom_range(0, 60);
                push_pct = $urandom_range(0, 80);
                thr_i    = LW'($urandom_range(0, DEPTH));
            end
            rx_en_i       = ($urandom_range(0, 99) < 95);
            frame_valid_i = ($urandom_range(0, 99) < push_pct);
            frame_data_i  = DATA_W'($urandom);
            parity_err_i  = 1'($urandom);
            frame_err_i   = 1'($urandom);
            pop_i         = ($urandom_range(0, 99) < pop_pct);
            bit_tick_i    = ($urandom_range(0, 99) < 30);
            flush_i       = ($urandom_range(0, 199) == 0);
            clr_ovr_i     = ($urandom_range(0, 99) < 3);
            reset_n       = ($urandom_range(0, 999) != 0);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
